// File: rtl/ifetch_pkg.sv
// Shared types and default sizes for the instruction-fetch controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        COMMIT,
        HALTED,
        FAULT
    } state_e;

endpackage

// File: rtl/ifetch_timer.sv
// Saturating WAIT-cycle counter; limit_hit marks the last cycle allowed before timeout.
// Latency: count updates one cycle after en; limit_hit is decoded from the registered count.
// Backpressure: none; clr has priority over en.
module ifetch_timer #(
    parameter  int LIMIT = 15,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic limit_hit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of ack-less WAIT cycles already spent, so the
    // LIMIT-th such cycle is the one where the count reads LIMIT-1.
    assign limit_hit = (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetches one instruction per PC address over req/ack and strobes PCWre once per capture.
// Latency: 3 cycles per instruction best case (IDLE, WAIT, COMMIT), +1 per ack-delay cycle.
// Backpressure: mem_req held with stable mem_addr until mem_ack; faults after TIMEOUT ack-less cycles.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Halt,
    output logic              PCWre,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] Instr,
    output logic              InstrValid,
    output logic              Fault
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              req_q, req_d;
    logic              fault_q, fault_d;
    logic              tmr_clr, tmr_en, tmr_limit;

    ifetch_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (Reset),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .limit_hit(tmr_limit)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Halt) begin
                    state_d = HALTED;
                end else if (Addr[1:0] != 2'b00) begin
                    state_d = FAULT;
                end else begin
                    addr_d  = Addr;
                    tmr_clr = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // An ack on the limit cycle still completes the fetch.
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = COMMIT;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_limit) begin
                        state_d = FAULT;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            HALTED: begin
                if (!Halt) begin
                    state_d = IDLE;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        req_d   = (state_d == WAIT);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign Instr      = instr_q;
    assign Fault      = fault_q;
    assign PCWre      = (state_q == COMMIT);
    assign InstrValid = (state_q == COMMIT);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized fetch traffic against a transaction-level scoreboard, plus fault/halt/reset corner cases.
module tb_ifetch_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [AW-1:0] Addr;
    logic          Halt;
    logic          PCWre;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] Instr;
    logic          InstrValid;
    logic          Fault;

    ifetch_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Addr      (Addr),
        .Halt      (Halt),
        .PCWre     (PCWre),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .Instr     (Instr),
        .InstrValid(InstrValid),
        .Fault     (Fault)
    );

    always #5 CLK = ~CLK;

    // One entry per fetch the bench expects the DUT to perform.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          done_cnt = 0;
    int          req_run = 0;
    int          rise_cycle = 0;
    bit          prev_req = 1'b0;
    int          cur_delay = 0;
    logic [31:0] cur_data = '0;
    bit          force_ack = 1'b0;
    logic [31:0] force_data = '0;
    bit          stray_en = 1'b0;
    int          wcnt = 0;

    always @(posedge CLK) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cycle);
        end
    endtask

    // Memory model: acks after cur_delay ack-less WAIT cycles; optional junk acks when idle.
    initial begin
        forever begin
            @(negedge CLK);
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = force_data;
                wcnt      = 0;
            end else if (!Reset) begin
                wcnt = 0;
            end else if (mem_req) begin
                if (wcnt == cur_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur_data;
                    wcnt      = 0;
                end else begin
                    mem_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (stray_en && ($urandom_range(3) == 0)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: checks every request cycle and every commit against the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (mem_req) begin
                if (!prev_req) begin
                    req_run    = 1;
                    rise_cycle = cycle;
                end else begin
                    req_run++;
                end
                if (exp_q.size() == 0) check("req_without_fetch", mem_req, 1'b0);
                else check("mem_addr", mem_addr, exp_q[0].addr);
            end
            prev_req = mem_req;
            if (PCWre || InstrValid) begin
                check("pcwre_eq_instrvalid", PCWre, InstrValid);
                if (exp_q.size() == 0) begin
                    check("commit_without_fetch", InstrValid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr", Instr, mon_e.data);
                    check("req_cycles", req_run, mon_e.delay + 1);
                    check("commit_latency", cycle - rise_cycle, mon_e.delay + 1);
                end
                done_cnt++;
            end
        end
    end

    task automatic wait_done(input int start, input int bound);
        int i = 0;
        while (done_cnt == start && i < bound) begin
            @(posedge CLK); #1;
            i++;
        end
        check("fetch_completed", done_cnt - start, 1);
    endtask

    // Called at posedge+1 with the DUT in IDLE or HALTED; returns likewise.
    task automatic do_fetch(input logic [31:0] a, input int d, input logic [31:0] dat, input bit halt_mid);
        exp_t e;
        int   start;
        bit   bad;
        e.addr = a; e.data = dat; e.delay = d;
        exp_q.push_back(e);
        Addr = a; cur_delay = d; cur_data = dat; Halt = 1'b0;
        start = done_cnt;
        if (halt_mid) begin
            for (int i = 0; i < 10 && !mem_req; i++) begin
                @(posedge CLK); #1;
            end
            Halt = 1'b1;
        end
        wait_done(start, d + 12);
        if (halt_mid) begin
            bad = 1'b0;
            repeat (3) begin
                @(negedge CLK);
                bad |= mem_req | PCWre | InstrValid | Fault;
            end
            check("halted_quiet", bad, 1'b0);
            @(posedge CLK); #1;
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b0; Halt = 1'b0; force_ack = 1'b0;
        exp_q.delete();
        @(posedge CLK); #1;
        Reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          d;
        bit          bad;
        exp_t        e;
        int          start;

        Reset = 1'b1; Halt = 1'b0; Addr = '0;
        #2 Reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_strobes", {PCWre, mem_req, InstrValid, Fault}, 4'b0000);
        check("reset_instr", Instr, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        Reset = 1'b1;

        do_fetch(32'h0, 0, 32'h20010005, 1'b0);
        do_fetch(32'h4, 4, 32'hA5A50004, 1'b0);
        do_fetch(32'h8, 2, 32'h11112222, 1'b1);
        do_fetch(32'h100, 0, 32'h33334444, 1'b0);

        stray_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            d = ($urandom_range(7) == 0) ? int'($urandom_range(TO - 1)) : int'($urandom_range(3));
            do_fetch(a, d, $urandom, $urandom_range(4) == 0);
        end
        stray_en = 1'b0;

        // Timeout: no ack ever.
        apply_reset();
        e.addr = 32'h40; e.data = '0; e.delay = 1000;
        exp_q.push_back(e);
        Addr = 32'h40; cur_delay = 1000;
        for (int i = 0; i < 40 && !Fault; i++) @(negedge CLK);
        check("timeout_fault", Fault, 1'b1);
        check("timeout_wait_cycles", req_run, TO);
        check("timeout_fault_cycle", cycle - rise_cycle, TO);
        Halt = 1'b1; Addr = 32'h80;
        bad = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            bad |= mem_req | PCWre | InstrValid | !Fault;
        end
        check("timeout_fault_sticky", bad, 1'b0);

        // Ack on the last allowed WAIT cycle wins over the timeout.
        apply_reset();
        do_fetch(32'h80, TO - 1, 32'h0BADF00D, 1'b0);
        check("ack_at_limit_no_fault", Fault, 1'b0);

        // Misaligned address faults one cycle after IDLE and stays faulted.
        Reset = 1'b0; Halt = 1'b0; exp_q.delete(); Addr = 32'h6;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(negedge CLK);
        check("misalign_idle_no_fault", Fault, 1'b0);
        @(negedge CLK);
        check("misalign_fault", Fault, 1'b1);
        Addr = 32'h10;
        bad = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            bad |= mem_req | PCWre | InstrValid | !Fault;
        end
        check("misalign_fault_sticky", bad, 1'b0);

        // Halt takes priority over misalignment.
        Reset = 1'b0; Addr = 32'h6; Halt = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("halt_over_misalign", {Fault, mem_req}, 2'b00);
        Halt = 1'b0;
        repeat (3) @(negedge CLK);
        check("misalign_after_halt", Fault, 1'b1);

        // Reset mid-fetch, then a late ack right after release.
        apply_reset();
        do_fetch(32'h1F0, 0, 32'hCAFE0001, 1'b0);
        e.addr = 32'h200; e.data = '0; e.delay = 1000;
        exp_q.push_back(e);
        Addr = 32'h200; cur_delay = 1000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre_abort_req", mem_req, 1'b1);
        Reset = 1'b0;
        #1;
        check("abort_strobes", {mem_req, PCWre, InstrValid, Fault}, 4'b0000);
        check("abort_instr", Instr, 32'h0);
        exp_q.delete();
        e.addr = 32'h300; e.data = 32'h12345678; e.delay = 1;
        exp_q.push_back(e);
        Addr = 32'h300; cur_delay = 1; cur_data = 32'h12345678;
        force_data = 32'hBADBAD00; force_ack = 1'b1;
        start = done_cnt;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        force_ack = 1'b0;
        @(negedge CLK);
        check("late_ack_instr", Instr, 32'h0);
        check("late_ack_pcwre", PCWre, 1'b0);
        wait_done(start, 12);
        check("fresh_fetch_instr", Instr, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
